// File: rtl/uart_tx_buffer_pkg.sv
// uart_tx_buffer_pkg: sequencer state encoding and byte width shared by the tx buffer files
package uart_tx_buffer_pkg;
  localparam int BYTE_W = 8;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: byte FIFO with occupancy count, full/empty decode and sticky overflow on dropped writes
module uart_sync_fifo
  import uart_tx_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              ovf_clr,
  output logic [BYTE_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);
  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic ovf_q, ovf_d, wr_ok;
  assign full = count_q == (ADDR_W+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign overflow = ovf_q;
  assign rd_data = mem_q[rd_ptr_q];
  always_comb begin
    wr_ok = wr_en && !full;
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = (wr_ok && !rd_en) ? count_q + 1'b1 : (rd_en && !wr_ok) ? count_q - 1'b1 : count_q;
    ovf_d = (wr_en && full) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
  end
  always_ff @(posedge clk)
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
    end
endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: queues host bytes and issues them one frame at a time to the UART transmitter
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              ovf_clr,
  input  logic              t_busy,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [BYTE_W-1:0] tx_data,
  output logic              t_start
);
  logic [1:0] state_q, state_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d, rd_data;
  logic t_start_q, t_start_d, pop;
  uart_sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .rd_en(pop),
    .ovf_clr(ovf_clr),
    .rd_data(rd_data),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow)
  );
  assign tx_data = tx_data_q;
  assign t_start = t_start_q;
  always_comb begin
    pop = state_q == IDLE && !empty;
    t_start_d = pop;
    tx_data_d = pop ? rd_data : tx_data_q;
    state_d = pop ? START
            : state_q == START ? WAIT_BUSY
            : (state_q == WAIT_BUSY && t_busy) ? WAIT_DONE
            : (state_q == WAIT_DONE && !t_busy) ? IDLE
            : state_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      tx_data_q <= '0;
      t_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_data_q <= tx_data_d;
      t_start_q <= t_start_d;
    end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: directed and random stimulus checked against a queue model of the tx buffer
module tb_uart_tx_buffer;
  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, ovf_clr = 1'b0, t_busy = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic full, empty, overflow, t_start;
  logic [ADDR_W:0] count;
  logic [7:0] tx_data;
  int checks = 0, errors = 0, n_starts = 0, mark = 0;
  logic [7:0] q[$];
  logic m_out = 1'b0, m_fresh = 1'b0, m_seen = 1'b0, m_ovf = 1'b0, m_start = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic force_busy = 1'b0;
  int dly = 0, bcnt = 0, tx_dly = 2, tx_len = 20;
  uart_tx_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .ovf_clr(ovf_clr),
    .t_busy(t_busy),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow),
    .tx_data(tx_data),
    .t_start(t_start)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic we, input logic [7:0] wd, input logic oc, input logic r);
    bit full_pre;
    @(negedge clk);
    if (dly > 0) begin
      dly--;
      if (dly == 0) bcnt = tx_len;
    end else if (bcnt > 0) bcnt--;
    t_busy = force_busy || bcnt > 0;
    wr_en = we;
    wr_data = wd;
    ovf_clr = oc;
    rst = r;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_out = 1'b0;
      m_fresh = 1'b0;
      m_seen = 1'b0;
      m_ovf = 1'b0;
      m_start = 1'b0;
      m_data = 8'h00;
      dly = 0;
      bcnt = 0;
    end else begin
      full_pre = q.size() == DEPTH;
      m_start = 1'b0;
      if (!m_out && q.size() > 0) begin
        m_data = q.pop_front();
        m_start = 1'b1;
        m_out = 1'b1;
        m_fresh = 1'b1;
        m_seen = 1'b0;
      end else if (m_out) begin
        if (m_fresh) m_fresh = 1'b0;
        else if (t_busy) m_seen = 1'b1;
        else if (m_seen) m_out = 1'b0;
      end
      if (we && !full_pre) q.push_back(wd);
      if (we && full_pre) m_ovf = 1'b1;
      else if (oc) m_ovf = 1'b0;
    end
    #1;
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("t_start", 32'(t_start), 32'(m_start));
    chk("tx_data", 32'(tx_data), 32'(m_data));
    if (t_start === 1'b1) begin
      n_starts++;
      if (!force_busy) begin
        dly = tx_dly;
        bcnt = 0;
      end
    end
  endtask
  initial begin
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_ovf", 32'(overflow), 32'd0);
    repeat (10) step(0, 8'h00, 0, 0);
    chk("idle_no_start", 32'(n_starts), 32'd0);
    tx_dly = 2;
    tx_len = 20;
    step(1, 8'hA5, 0, 0);
    chk("a5_count_up", 32'(count), 32'd1);
    chk("a5_not_yet", 32'(t_start), 32'd0);
    step(0, 8'h00, 0, 0);
    chk("a5_start", 32'(t_start), 32'd1);
    chk("a5_data", 32'(tx_data), 32'hA5);
    chk("a5_count_down", 32'(count), 32'd0);
    repeat (30) step(0, 8'h00, 0, 0);
    chk("a5_single_pulse", 32'(n_starts), 32'd1);
    mark = n_starts;
    for (int i = 1; i <= 3; i++) step(1, 8'(i), 0, 0);
    repeat (90) step(0, 8'h00, 0, 0);
    chk("burst_pulses", 32'(n_starts - mark), 32'd3);
    chk("burst_drained", 32'(empty), 32'd1);
    force_busy = 1'b1;
    step(1, 8'h10, 0, 0);
    repeat (3) step(0, 8'h00, 0, 0);
    for (int i = 0; i < 17; i++) step(1, 8'(8'h20 + i), 0, 0);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count", 32'(count), 32'(DEPTH));
    chk("ovf_flag", 32'(overflow), 32'd1);
    step(0, 8'h00, 1, 0);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    force_busy = 1'b0;
    tx_dly = 2;
    tx_len = 3;
    for (int n = 0; n < 50; n++) begin
      step(1, 8'hEE, 0, 0);
      if (t_start === 1'b1) break;
    end
    chk("pop_full_start", 32'(t_start), 32'd1);
    chk("pop_full_count", 32'(count), 32'(DEPTH - 1));
    chk("pop_full_ovf", 32'(overflow), 32'd1);
    chk("pop_full_data", 32'(tx_data), 32'h20);
    for (int n = 0; n < 800; n++) begin
      step(0, 8'h00, 0, 0);
      if (q.size() == 0 && !m_out) break;
    end
    chk("drain_empty", 32'(empty), 32'd1);
    tx_dly = 2;
    tx_len = 20;
    for (int i = 0; i < 6; i++) step(1, 8'(8'h40 + i), 0, 0);
    for (int n = 0; n < 60; n++) begin
      if (m_out && m_seen) break;
      step(0, 8'h00, 0, 0);
    end
    chk("wd_queued", 32'(count), 32'd5);
    step(0, 8'h00, 0, 1);
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_empty", 32'(empty), 32'd1);
    mark = n_starts;
    repeat (10) step(0, 8'h00, 0, 0);
    chk("rst_mid_quiet", 32'(n_starts - mark), 32'd0);
    step(1, 8'h77, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("post_rst_start", 32'(t_start), 32'd1);
    chk("post_rst_data", 32'(tx_data), 32'h77);
    for (int i = 0; i < 600; i++) begin
      tx_dly = $urandom_range(4, 2);
      tx_len = $urandom_range(6, 1);
      step($urandom_range(99, 0) < 40, 8'($urandom), $urandom_range(99, 0) < 5, $urandom_range(999, 0) < 5);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
